regfile_bypass_sb: RTL and testbench
====================================

// Module: regfile_bypass_sb
// PURPOSE
//   Parametrised 2-read/1-write register file for the pipelined MIPS core.
//   Adds write-to-read bypass, a hardwired-zero register 0 and a per-register
//   pending (scoreboard) bit. Decode uses the pending bits to detect RAW hazards.
//   Sits between ID (reads, issue) and WB (write-back).
// PARAMETERS
//   DATA_W    32  register width in bits
//   NUM_REGS  32  register count, power of two, >= 2
//   ZERO_REG  1   1: register 0 reads 0; writes and issues to it are ignored
//   BYPASS    1   1: same-cycle write data forwarded to read ports
//   ADDR_W    $clog2(NUM_REGS)  localparam, not overridable
// PORTS
//   clk        in   1       clock; all state updates on posedge
//   reset      in   1       reset, asynchronous, active-high
//   rd_addr_a  in   ADDR_W  read port A address
//   rd_addr_b  in   ADDR_W  read port B address
//   rd_data_a  out  DATA_W  read port A data, combinational
//   rd_data_b  out  DATA_W  read port B data, combinational
//   rd_busy_a  out  1       register A has an outstanding write (hazard)
//   rd_busy_b  out  1       register B has an outstanding write (hazard)
//   wr_en      in   1       write-back strobe
//   wr_addr    in   ADDR_W  write-back destination
//   wr_data    in   DATA_W  write-back data
//   iss_en     in   1       instruction issued with destination iss_addr
//   iss_addr   in   ADDR_W  destination to mark pending
//   flush      in   1       squash all in-flight: clear every pending bit
// BEHAVIOUR
//   - Reset (async): all registers = 0, all pending bits = 0.
//     Outputs then read 0 with busy 0.
//   - Write: posedge clk with wr_en=1 stores wr_data into regs[wr_addr]
//     and clears pending[wr_addr]. Write latency is 1 cycle.
//   - Read: rd_data_x = regs[rd_addr_x] with zero added wait cycles.
//     BYPASS=1 and wr_en and wr_addr==rd_addr_x: returns wr_data instead.
//   - ZERO_REG=1: address 0 always reads 0 with busy 0. Writes/issues to
//     address 0 have no effect (pending[0] stays 0).
//   - Issue: posedge clk with iss_en=1 sets pending[iss_addr].
//   - Busy: rd_busy_x = pending[rd_addr_x], with one exception:
//     BYPASS=1 and wr_en and wr_addr==rd_addr_x gives 0 (value available now).
//   - Same cycle, iss_en and wr_en to the same address: regs updated; pending
//     ends 1 (newer producer wins).
//   - flush=1 at posedge: all pending bits cleared. A same-cycle wr_en still
//     writes data. A same-cycle iss_en is dropped (flush dominates issue).
//   - Multiple issues to a pending register keep it pending. One write-back
//     clears it (single-outstanding-writer model; decode must stall a second
//     issue to a busy destination).
//   - Reset asserted mid-operation: state clears immediately.
//     Same-cycle writes/issues are lost.
// STRUCTURE
//   - Package regfile_pkg: DATA_W/NUM_REGS defaults, REG_ZERO=0,
//     REG_RA=31 constants.
//   - Sub-module regfile_scoreboard: pending-bit vector with
//     set/clear/flush and two busy lookups.
//   - Top: register array, write logic, bypass muxes, zero-register masking.
// TESTING
//   1 reset, then read all 32 regs -> every rd_data=0, every rd_busy=0
//   2 wr r9=0x0000_0002 at cycle n; read r9 at cycle n
//       BYPASS=1 -> 0x2 at cycle n
//       BYPASS=0 -> old value at n, 0x2 at n+1
//   3 wr r0=0xDEAD_BEEF, iss r0 -> r0 reads 0, busy 0 on both ports
//   4 iss r18 at cycle n -> busy_a(r18)=1 from n+1
//       wr r18=0x3 at m -> busy 0 and data 0x3 at m (bypass), busy 0 after
//   5 iss and wr r20 in the same cycle -> regs[20]=wr_data, busy(r20)=1 next cycle
//   6 iss r8,r22, then flush + iss r23 same cycle
//       -> all busy 0 after; r23 not pending
//   7 assert reset mid-stream with pending r8 and r8=0x1
//       -> r8 reads 0, busy 0 immediately, without a clk edge

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants for the register-file slice.
// Default geometry plus well-known register indices.
package regfile_pkg;

  localparam int DATA_W_DEF   = 32;
  localparam int NUM_REGS_DEF = 32;

  localparam int REG_ZERO = 0;
  localparam int REG_RA   = 31;

  // True when addr names the hardwired-zero register
  // and that register is enabled.
  function automatic logic is_zero_reg(
    input int   zero_en,
    input logic [31:0] addr
  );
    return (zero_en != 0) && (addr == 32'(REG_ZERO));
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-bit scoreboard: one bit per architectural register.
// Ports: set (issue), clr (write-back), flush, two raw busy lookups.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int ZERO_REG = 1,
  localparam int ADDR_W  = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              set_en_i,
  input  logic [ADDR_W-1:0] set_addr_i,
  input  logic              clr_en_i,
  input  logic [ADDR_W-1:0] clr_addr_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] lk_addr_a_i,
  input  logic [ADDR_W-1:0] lk_addr_b_i,
  output logic              busy_a_o,
  output logic              busy_b_o
);

  logic [NUM_REGS-1:0] pend_q;
  logic [NUM_REGS-1:0] pend_d;

  // Order matters: a same-cycle issue overrides the
  // write-back clear, and flush overrides both.
  always_comb begin
    pend_d = pend_q;
    if (clr_en_i) begin
      pend_d[clr_addr_i] = 1'b0;
    end
    if (set_en_i) begin
      pend_d[set_addr_i] = 1'b1;
    end
    if (flush_i) begin
      pend_d = '0;
    end
    if (ZERO_REG != 0) begin
      pend_d[REG_ZERO] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  assign busy_a_o = pend_q[lk_addr_a_i];
  assign busy_b_o = pend_q[lk_addr_b_i];

endmodule

// File: rtl/regfile_bypass_sb.sv
// 2R/1W register file with write bypass, zero register and scoreboard.
// Ports: rd_* (ID reads + hazard), wr_* (WB), iss_* (issue), flush.
module regfile_bypass_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int ADDR_W  = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              rd_busy_a,
  output logic              rd_busy_b,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_addr,
  input  logic              flush
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];

  logic wr_zero;
  logic iss_zero;
  logic wr_ok;
  logic iss_ok;

  assign wr_zero  = is_zero_reg(ZERO_REG, 32'(wr_addr));
  assign iss_zero = is_zero_reg(ZERO_REG, 32'(iss_addr));
  assign wr_ok    = wr_en && !wr_zero;
  // Flush squashes the issue at the scoreboard itself.
  assign iss_ok   = iss_en && !iss_zero;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_ok) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  logic sb_busy_a;
  logic sb_busy_b;

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk         (clk),
    .reset       (reset),
    .set_en_i    (iss_ok),
    .set_addr_i  (iss_addr),
    .clr_en_i    (wr_ok),
    .clr_addr_i  (wr_addr),
    .flush_i     (flush),
    .lk_addr_a_i (rd_addr_a),
    .lk_addr_b_i (rd_addr_b),
    .busy_a_o    (sb_busy_a),
    .busy_b_o    (sb_busy_b)
  );

  logic zero_a;
  logic zero_b;
  logic hit_a;
  logic hit_b;

  assign zero_a = is_zero_reg(ZERO_REG, 32'(rd_addr_a));
  assign zero_b = is_zero_reg(ZERO_REG, 32'(rd_addr_b));

  // A write landing this cycle makes the value
  // available now, so it also cancels the hazard.
  assign hit_a = (BYPASS != 0) && wr_en
              && (wr_addr == rd_addr_a);
  assign hit_b = (BYPASS != 0) && wr_en
              && (wr_addr == rd_addr_b);

  always_comb begin
    rd_data_a = regs_q[rd_addr_a];
    rd_busy_a = sb_busy_a;
    if (zero_a) begin
      rd_data_a = '0;
      rd_busy_a = 1'b0;
    end else if (hit_a) begin
      rd_data_a = wr_data;
      rd_busy_a = 1'b0;
    end
  end

  always_comb begin
    rd_data_b = regs_q[rd_addr_b];
    rd_busy_b = sb_busy_b;
    if (zero_b) begin
      rd_data_b = '0;
      rd_busy_b = 1'b0;
    end else if (hit_b) begin
      rd_data_b = wr_data;
      rd_busy_b = 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_bypass_sb.sv
// Bench for regfile_bypass_sb: reference model + directed vectors.
// Checks a BYPASS=1 and a BYPASS=0 instance against one model.
module tb_regfile_bypass_sb;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rd_addr_a, rd_addr_b;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        iss_en;
  logic [4:0]  iss_addr;
  logic        flush;

  logic [31:0] da1, db1, da0, db0;
  logic        ba1, bb1, ba0, bb0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  regfile_bypass_sb dut (
    .clk(clk), .reset(reset),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(da1), .rd_data_b(db1),
    .rd_busy_a(ba1), .rd_busy_b(bb1),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush)
  );

  regfile_bypass_sb #(.BYPASS(0)) dut0 (
    .clk(clk), .reset(reset),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(da0), .rd_data_b(db0),
    .rd_busy_a(ba0), .rd_busy_b(bb0),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush)
  );

  // Architectural model: register values and outstanding writers.
  logic [31:0] mregs [32] = '{default: '0};
  bit          mpend [32] = '{default: 1'b0};

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        mregs[i] <= '0;
        mpend[i] <= 1'b0;
      end
    end else begin
      if (wr_en && wr_addr != 0) begin
        mregs[wr_addr] <= wr_data;
        mpend[wr_addr] <= 1'b0;
      end
      if (iss_en && !flush && iss_addr != 0)
        mpend[iss_addr] <= 1'b1;
      if (flush)
        for (int i = 0; i < 32; i++) mpend[i] <= 1'b0;
    end
  end

  function automatic logic [31:0] exp_data(bit byp, logic [4:0] a);
    if (a == 0) return 32'h0;
    if (byp && wr_en && wr_addr == a) return wr_data;
    return mregs[a];
  endfunction

  function automatic logic exp_busy(bit byp, logic [4:0] a);
    if (a == 0) return 1'b0;
    if (byp && wr_en && wr_addr == a) return 1'b0;
    return mpend[a];
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin
    chk("mdl_da1", da1, exp_data(1, rd_addr_a));
    chk("mdl_db1", db1, exp_data(1, rd_addr_b));
    chk("mdl_ba1", 32'(ba1), 32'(exp_busy(1, rd_addr_a)));
    chk("mdl_bb1", 32'(bb1), 32'(exp_busy(1, rd_addr_b)));
    chk("mdl_da0", da0, exp_data(0, rd_addr_a));
    chk("mdl_db0", db0, exp_data(0, rd_addr_b));
    chk("mdl_ba0", 32'(ba0), 32'(exp_busy(0, rd_addr_a)));
    chk("mdl_bb0", 32'(bb0), 32'(exp_busy(0, rd_addr_b)));
  end

  task automatic idle();
    wr_en = 0; wr_addr = 0; wr_data = 0;
    iss_en = 0; iss_addr = 0; flush = 0;
  endtask

  // Advance one clock; inputs change 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    rd_addr_a = 0; rd_addr_b = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    tick();

    // 1: every register reads zero, not busy
    for (int i = 0; i < 32; i++) begin
      rd_addr_a = 5'(i); rd_addr_b = 5'(31 - i);
      settle();
      chk("t1_da", da1, 32'h0);
      chk("t1_db", db1, 32'h0);
      chk("t1_ba", 32'(ba1), 32'h0);
      chk("t1_bb", 32'(bb1), 32'h0);
      tick();
    end

    // 2: bypass vs no bypass on the write cycle
    wr_en = 1; wr_addr = 9; wr_data = 32'h2;
    rd_addr_a = 9; rd_addr_b = 9;
    settle();
    chk("t2_byp_n", da1, 32'h2);
    chk("t2_nobyp_n", da0, 32'h0);
    tick();
    idle();
    settle();
    chk("t2_byp_n1", da1, 32'h2);
    chk("t2_nobyp_n1", da0, 32'h2);
    tick();

    // 3: register 0 is immune to writes and issues
    wr_en = 1; wr_addr = 0; wr_data = 32'hDEAD_BEEF;
    iss_en = 1; iss_addr = 0;
    rd_addr_a = 0; rd_addr_b = 0;
    settle();
    chk("t3_da_n", da1, 32'h0);
    chk("t3_bb_n", 32'(bb1), 32'h0);
    tick();
    idle();
    settle();
    chk("t3_da", da1, 32'h0);
    chk("t3_db", db0, 32'h0);
    chk("t3_ba", 32'(ba1), 32'h0);
    chk("t3_bb", 32'(bb0), 32'h0);
    tick();

    // 4: issue then write-back of r18
    iss_en = 1; iss_addr = 18;
    rd_addr_a = 18; rd_addr_b = 18;
    tick();
    idle();
    settle();
    chk("t4_busy", 32'(ba1), 32'h1);
    tick();
    wr_en = 1; wr_addr = 18; wr_data = 32'h3;
    settle();
    chk("t4_wb_busy1", 32'(ba1), 32'h0);
    chk("t4_wb_data1", da1, 32'h3);
    chk("t4_wb_busy0", 32'(ba0), 32'h1);
    tick();
    idle();
    settle();
    chk("t4_after_b", 32'(bb1), 32'h0);
    chk("t4_after_d", db0, 32'h3);
    tick();

    // 5: issue and write r20 together: data lands, still pending
    iss_en = 1; iss_addr = 20;
    wr_en = 1; wr_addr = 20; wr_data = 32'h55;
    rd_addr_a = 20; rd_addr_b = 20;
    tick();
    idle();
    settle();
    chk("t5_data", da1, 32'h55);
    chk("t5_busy", 32'(ba1), 32'h1);
    tick();
    wr_en = 1; wr_addr = 20; wr_data = 32'h56;
    tick();
    idle();

    // 6: flush clears pending, drops issue, keeps write
    iss_en = 1; iss_addr = 8;
    tick();
    iss_en = 1; iss_addr = 22;
    tick();
    iss_en = 1; iss_addr = 5;
    tick();
    idle();
    rd_addr_a = 8; rd_addr_b = 22;
    settle();
    chk("t6_pre8", 32'(ba1), 32'h1);
    chk("t6_pre22", 32'(bb1), 32'h1);
    flush = 1; iss_en = 1; iss_addr = 23;
    wr_en = 1; wr_addr = 5; wr_data = 32'h5;
    tick();
    idle();
    settle();
    chk("t6_b8", 32'(ba1), 32'h0);
    chk("t6_b22", 32'(bb0), 32'h0);
    rd_addr_a = 23; rd_addr_b = 5;
    settle();
    chk("t6_b23", 32'(ba1), 32'h0);
    chk("t6_d5", db0, 32'h5);
    chk("t6_b5", 32'(bb1), 32'h0);
    tick();

    // 7: asynchronous reset mid-stream
    wr_en = 1; wr_addr = 8; wr_data = 32'h1;
    tick();
    iss_en = 1; iss_addr = 8;
    tick();
    idle();
    rd_addr_a = 8; rd_addr_b = 8;
    settle();
    chk("t7_pre_d", da1, 32'h1);
    chk("t7_pre_b", 32'(ba1), 32'h1);
    wr_en = 1; wr_addr = 8; wr_data = 32'h77;
    iss_en = 1; iss_addr = 8;
    #1 reset = 1'b1;
    #1;
    idle();
    settle();
    chk("t7_rst_d", da1, 32'h0);
    chk("t7_rst_b", 32'(ba1), 32'h0);
    chk("t7_rst_d0", db0, 32'h0);
    wr_en = 1; wr_addr = 8; wr_data = 32'h77;
    iss_en = 1; iss_addr = 8;
    tick();
    idle();
    reset = 1'b0;
    tick();
    chk("t7_post_d", da1, 32'h0);
    chk("t7_post_b", 32'(bb1), 32'h0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
